camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture.sv | 137 +++++++++++++
 tb/tb_camera_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// camera_capture: RGB565 camera byte stream to RGB332 frame-buffer writes.
// Ports: CLOCK/RESET (sync, active-high); CAM_PCLK/CAM_HREF/CAM_VSYNC/CAM_DATA async camera bus;
// WR_ADDR/WR_DATA/WR_EN frame-buffer write port; FRAME_DONE end-of-frame pulse;
// RED_COUNT/BLUE_COUNT per-frame colour counts, live only when CAPTURE_STATS_EN is defined.
module camera_capture #(
  parameter int IMG_W = 176,
  parameter int IMG_H = 144
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CAM_PCLK,
  input  logic        CAM_HREF,
  input  logic        CAM_VSYNC,
  input  logic [7:0]  CAM_DATA,
  output logic [14:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        WR_EN,
  output logic        FRAME_DONE,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT
);
  typedef enum logic [1:0] {SYNC, WAIT_START, CAPTURE} state_t;
  state_t      r_state;
  // bit 0 = stage 1, bit 1 = stage 2 (decision), bit 2 = previous stage 2 (edge reference)
  logic [2:0]  r_pclk, r_href, r_vsync;
  logic [7:0]  r_data_s1, r_data_s2;
  logic [5:0]  r_byte0;
  logic        r_phase, r_wr_en, r_frame_done;
  logic [14:0] r_x, r_y, r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        w_pclk_rise, w_href_fall, w_vs_rise, w_vs_fall, w_fits, w_wr;
  logic [14:0] w_addr;
  logic [7:0]  w_pixel;
  assign w_pclk_rise = r_pclk[1] & ~r_pclk[2];
  assign w_href_fall = ~r_href[1] & r_href[2];
  assign w_vs_rise   = r_vsync[1] & ~r_vsync[2];
  assign w_vs_fall   = ~r_vsync[1] & r_vsync[2];
  assign w_fits      = (r_x < 15'(IMG_W)) && (r_y < 15'(IMG_H));
  assign w_wr        = w_pclk_rise && r_href[1] && r_phase && w_fits;
  assign w_addr      = r_y * 15'(IMG_W) + r_x;
  assign w_pixel     = {r_byte0, r_data_s2[4:3]};
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= SYNC;
      r_pclk       <= '0;
      r_href       <= '0;
      r_vsync      <= '0;
      r_data_s1    <= '0;
      r_data_s2    <= '0;
      r_byte0      <= '0;
      r_phase      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pclk       <= {r_pclk[1:0], CAM_PCLK};
      r_href       <= {r_href[1:0], CAM_HREF};
      r_vsync      <= {r_vsync[1:0], CAM_VSYNC};
      r_data_s1    <= CAM_DATA;
      r_data_s2    <= r_data_s1;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        SYNC: if (r_vsync[1]) r_state <= WAIT_START;
        WAIT_START: begin
          if (w_vs_fall) begin
            r_state <= CAPTURE;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_vs_rise) begin
            r_state      <= WAIT_START;
            r_frame_done <= 1'b1;
          end else if (w_href_fall) begin
            r_phase <= 1'b0;
            if (r_x != '0) begin
              r_x <= '0;
              r_y <= (r_y < 15'(IMG_H)) ? r_y + 15'd1 : r_y;
            end
          end else if (w_pclk_rise && r_href[1]) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_byte0 <= {r_data_s2[7:5], r_data_s2[2:0]};
            else r_x <= (r_x < 15'(IMG_W)) ? r_x + 15'd1 : r_x;
            if (w_wr) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr;
              r_wr_data <= w_pixel;
            end
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end
  assign WR_EN      = r_wr_en;
  assign WR_ADDR    = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign FRAME_DONE = r_frame_done;
`ifdef CAPTURE_STATS_EN
  logic [14:0] r_red_acc, r_blue_acc, r_red_count, r_blue_count;
  logic        w_stat_wr, w_red, w_blue;
  assign w_stat_wr = (r_state == CAPTURE) && !w_vs_rise && w_wr;
  assign w_red     = (r_byte0[5:3] > 3'd4) && (r_data_s2[4:3] < 2'd2);
  assign w_blue    = (r_data_s2[4:3] == 2'd3) && (r_byte0[5:3] < 3'd3);
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_red_acc    <= '0;
      r_blue_acc   <= '0;
      r_red_count  <= '0;
      r_blue_count <= '0;
    end else begin
      if (r_state == WAIT_START && w_vs_fall) begin
        r_red_acc  <= '0;
        r_blue_acc <= '0;
      end else if (w_stat_wr) begin
        r_red_acc  <= r_red_acc + 15'(w_red);
        r_blue_acc <= r_blue_acc + 15'(w_blue);
      end
      if (r_state == CAPTURE && w_vs_rise) begin
        r_red_count  <= r_red_acc;
        r_blue_count <= r_blue_acc;
      end
    end
  end
  assign RED_COUNT  = r_red_count;
  assign BLUE_COUNT = r_blue_count;
`else
  assign RED_COUNT  = '0;
  assign BLUE_COUNT = '0;
`endif
endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: drives camera byte streams into two capture instances (176x144 and 4x3) and scoreboards their writes.
module tb_camera_capture;
  logic clk = 1'b0, rst = 1'b1, cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0;
  logic [7:0] cam_data = '0;
  logic [14:0] a0, a1, rc0, rc1, bc0, bc1;
  logic [7:0] d0, d1;
  logic e0, e1, fd0, fd1;
  typedef struct {int addr; int data;} wr_t;
  typedef struct {int r; int b;} done_t;
  typedef struct {logic [7:0] b0; logic [7:0] b1; logic [7:0] exp;} vec_t;
  wr_t wq0[$], wq1[$];
  done_t dq0[$], dq1[$];
  vec_t tbl[6];
  int checks = 0, errors = 0;
  int mx[2], my[2], rcm[2], bcm[2], la[2], ld[2];
  bit cap = 0, ph = 0;
  logic [7:0] pb0;
  camera_capture u_dut0 (
    .CLOCK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href), .CAM_VSYNC(cam_vsync),
    .CAM_DATA(cam_data), .WR_ADDR(a0), .WR_DATA(d0), .WR_EN(e0), .FRAME_DONE(fd0),
    .RED_COUNT(rc0), .BLUE_COUNT(bc0));
  camera_capture #(.IMG_W(4), .IMG_H(3)) u_dut1 (
    .CLOCK(clk), .RESET(rst), .CAM_PCLK(cam_pclk), .CAM_HREF(cam_href), .CAM_VSYNC(cam_vsync),
    .CAM_DATA(cam_data), .WR_ADDR(a1), .WR_DATA(d1), .WR_EN(e1), .FRAME_DONE(fd1),
    .RED_COUNT(rc1), .BLUE_COUNT(bc1));
  always #20 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int conv(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    p = {x[7:5], x[2:0], y[4:3]};
    return int'(p);
  endfunction
  task automatic form(input int d, input logic [7:0] p0, input logic [7:0] p1, input int ex);
    int w, h;
    wr_t e;
    w = d ? 4 : 176;
    h = d ? 3 : 144;
    if (mx[d] < w && my[d] < h) begin
      e.addr = my[d] * w + mx[d];
      e.data = ex >= 0 ? ex : conv(p0, p1);
      if (d == 0) wq0.push_back(e); else wq1.push_back(e);
      if (p0[7:5] > 3'd4 && p1[4:3] < 2'd2) rcm[d]++;
      if (p1[4:3] == 2'd3 && p0[7:5] < 3'd3) bcm[d]++;
    end
    if (mx[d] < w) mx[d]++;
  endtask
  task automatic send_byte(input logic [7:0] b, input int ex = -1);
    if (cap && cam_href) begin
      if (!ph) begin
        pb0 = b;
        ph = 1;
      end else begin
        ph = 0;
        for (int d = 0; d < 2; d++) form(d, pb0, b, ex);
      end
    end
    cam_data = b;
    cam_pclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 cam_pclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic send_pixel(input logic [7:0] x, input logic [7:0] y);
    send_byte(x);
    send_byte(y);
  endtask
  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) send_pixel(8'($urandom), 8'($urandom));
  endtask
  task automatic line_begin();
    cam_href = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic line_end();
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    ph = 0;
    if (cap) for (int d = 0; d < 2; d++) if (mx[d] != 0) begin
      if (my[d] < (d ? 3 : 144)) my[d]++;
      mx[d] = 0;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask
  task automatic vsync_pulse();
    done_t x;
    if (cap) for (int d = 0; d < 2; d++) begin
`ifdef CAPTURE_STATS_EN
      x.r = rcm[d];
      x.b = bcm[d];
`else
      x.r = 0;
      x.b = 0;
`endif
      if (d == 0) dq0.push_back(x); else dq1.push_back(x);
    end
    cap = 1;
    ph = 0;
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; rcm[d] = 0; bcm[d] = 0;
    end
    cam_vsync = 1'b1;
    repeat (8) @(posedge clk);
    #1 cam_vsync = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("done_missing0", dq0.size(), 0);
    chk("done_missing1", dq1.size(), 0);
    chk("writes_missing0", wq0.size(), 0);
    chk("writes_missing1", wq1.size(), 0);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_wr_en0", int'(e0), 0);      chk("rst_wr_en1", int'(e1), 0);
    chk("rst_wr_addr0", int'(a0), 0);    chk("rst_wr_addr1", int'(a1), 0);
    chk("rst_wr_data0", int'(d0), 0);    chk("rst_wr_data1", int'(d1), 0);
    chk("rst_frame_done0", int'(fd0), 0); chk("rst_frame_done1", int'(fd1), 0);
    chk("rst_red0", int'(rc0), 0);       chk("rst_red1", int'(rc1), 0);
    chk("rst_blue0", int'(bc0), 0);      chk("rst_blue1", int'(bc1), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    cap = 0;
    ph = 0;
    la = '{0, 0};
    ld = '{0, 0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs();
  endtask
  task automatic mon(input int d, input logic en, input logic [14:0] a, input logic [7:0] dt,
                     input logic fd, input logic [14:0] r, input logic [14:0] b);
    wr_t e;
    done_t x;
    int n;
    if (en) begin
      n = d ? wq1.size() : wq0.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write%0d: got addr %0d data %0d, expected no write", d, a, dt);
      end else begin
        if (d == 0) e = wq0.pop_front(); else e = wq1.pop_front();
        chk(d ? "wr_addr1" : "wr_addr0", int'(a), e.addr);
        chk(d ? "wr_data1" : "wr_data0", int'(dt), e.data);
        la[d] = e.addr;
        ld[d] = e.data;
      end
    end else begin
      chk(d ? "hold_addr1" : "hold_addr0", int'(a), la[d]);
      chk(d ? "hold_data1" : "hold_data0", int'(dt), ld[d]);
    end
    if (fd) begin
      n = d ? dq1.size() : dq0.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done%0d: got pulse, expected none", d);
      end else begin
        if (d == 0) x = dq0.pop_front(); else x = dq1.pop_front();
        chk(d ? "red_count1" : "red_count0", int'(r), x.r);
        chk(d ? "blue_count1" : "blue_count0", int'(b), x.b);
      end
    end
  endtask
  always @(negedge clk) if (!rst) begin
    mon(0, e0, a0, d0, fd0, rc0, bc0);
    mon(1, e1, a1, d1, fd1, rc1, bc1);
  end
  initial begin
    tbl[0] = '{8'hF8, 8'h00, 8'hE0};
    tbl[1] = '{8'h07, 8'hE0, 8'h1C};
    tbl[2] = '{8'h00, 8'h1F, 8'h03};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{8'hA5, 8'h5A, 8'hB7};
    tbl[5] = '{8'h3C, 8'hC3, 8'h30};
    la = '{0, 0};
    ld = '{0, 0};
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    line_begin();
    rand_pixels(2);
    line_end();
    vsync_pulse();
    line_begin();
    for (int i = 0; i < 6; i++) begin
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1, int'(tbl[i].exp));
    end
    line_end();
    send_byte(8'h55);
    send_byte(8'hAA);
    cam_pclk = 1'b0;
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      line_begin();
      rand_pixels(2);
      line_end();
    end
    vsync_pulse();
    line_begin();
    rand_pixels(180);
    line_end();
    line_begin();
    rand_pixels(2);
    line_end();
    vsync_pulse();
    line_begin();
    send_pixel(8'hF8, 8'h00);
    send_pixel(8'h07, 8'hE0);
    send_byte(8'hAA);
    line_end();
    line_begin();
    send_pixel(8'h00, 8'h1F);
    send_pixel(8'hF8, 8'h00);
    line_end();
    vsync_pulse();
    line_begin();
    for (int i = 0; i < 6; i++) send_pixel(8'hF8, 8'h00);
    line_end();
    line_begin();
    for (int i = 0; i < 3; i++) send_pixel(8'h00, 8'h1F);
    line_end();
    vsync_pulse();
    line_begin();
    rand_pixels(10);
    do_reset();
    rand_pixels(5);
    line_end();
    line_begin();
    rand_pixels(3);
    line_end();
    vsync_pulse();
    line_begin();
    rand_pixels(2);
    line_end();
    vsync_pulse();
    repeat (4) @(posedge clk);
    #1;
    chk("final_writes0", wq0.size(), 0);
    chk("final_writes1", wq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
